// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the state encoding and the bus widths used by the loader.
package instr_loader_pkg;

  localparam int INSTR_W = 32;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    LD_LOAD  = 2'd0,
    LD_WRITE = 2'd1,
    LD_DONE  = 2'd2
  } ld_state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Host byte stream plus the instr_mem write port, bundled as one interface.
// The master modport is the host side; the slave modport is the loader.
interface instr_loader_if
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 5
);

  logic [BYTE_W-1:0]  in_byte;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [ADDR_W-1:0]  mem_a;
  logic [INSTR_W-1:0] mem_d;
  logic               mem_we;

  modport master (
    output in_byte, in_valid, in_last,
    input  in_ready, mem_a, mem_d, mem_we
  );

  modport slave (
    input  in_byte, in_valid, in_last,
    output in_ready, mem_a, mem_d, mem_we
  );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Packs up to four bytes MSB-first into a 32-bit word.
// o_word is the word as it stands after the current shift, left-aligned.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic [BYTE_W-1:0]  i_byte,
  output logic [INSTR_W-1:0] o_word,
  output logic               o_word_full
);

  logic [INSTR_W-1:0] r_word;
  logic [1:0]         r_count;
  logic [INSTR_W-1:0] w_shifted;

  // Short final words are zero-filled in the low bytes so they land MSB-first.
  always_comb begin
    w_shifted = {r_word[INSTR_W-BYTE_W-1:0], i_byte};
    case (r_count)
      2'd0:    o_word = {w_shifted[7:0],  24'd0};
      2'd1:    o_word = {w_shifted[15:0], 16'd0};
      2'd2:    o_word = {w_shifted[23:0], 8'd0};
      default: o_word = w_shifted;
    endcase
    o_word_full = i_shift && (r_count == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_count <= 2'd0;
    end else if (i_clear) begin
      r_word  <= '0;
      r_count <= 2'd0;
    end else if (i_shift) begin
      r_word  <= w_shifted;
      r_count <= r_count + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Fills instr_mem from a host byte stream and holds the CPU until the image is complete.
// The write address never wraps; the last word slot ends the load by itself.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_loader_if.slave     bus,
  input  logic              reload,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  ld_state_e          r_state;
  logic               r_last;
  logic [ADDR_W-1:0]  r_mem_a;
  logic [INSTR_W-1:0] r_mem_d;
  logic               r_mem_we;
  logic               r_cpu_hold;
  logic               r_done;
  logic [ADDR_W:0]    r_word_count;

  logic               w_accept;
  logic               w_clear;
  logic [INSTR_W-1:0] w_word;
  logic               w_word_full;

  assign w_accept = bus.in_valid && (r_state == LD_LOAD);
  assign w_clear  = (r_state == LD_WRITE);

  assign bus.in_ready = (r_state == LD_LOAD);
  assign bus.mem_a    = r_mem_a;
  assign bus.mem_d    = r_mem_d;
  assign bus.mem_we   = r_mem_we;
  assign cpu_hold     = r_cpu_hold;
  assign done         = r_done;
  assign word_count   = r_word_count;

  byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_shift     (w_accept),
    .i_byte      (bus.in_byte),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // r_last records whether the pending write closes the image (in_last or final slot).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LD_LOAD;
      r_last       <= 1'b0;
      r_mem_a      <= '0;
      r_mem_d      <= '0;
      r_mem_we     <= 1'b0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        LD_LOAD: begin
          if (w_accept && (w_word_full || bus.in_last)) begin
            r_mem_d  <= w_word;
            r_mem_we <= 1'b1;
            r_last   <= bus.in_last || (r_mem_a == LAST_ADDR);
            r_state  <= LD_WRITE;
          end
        end
        LD_WRITE: begin
          r_mem_we <= 1'b0;
          if (r_word_count != DEPTH_CNT) begin
            r_word_count <= r_word_count + 1'b1;
          end
          if (r_last) begin
            r_state    <= LD_DONE;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_mem_a <= r_mem_a + 1'b1;
            r_state <= LD_LOAD;
          end
        end
        LD_DONE: begin
          if (reload) begin
            r_state      <= LD_LOAD;
            r_mem_a      <= '0;
            r_word_count <= '0;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
          end
        end
        default: r_state <= LD_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a scoreboard of expected instr_mem writes
// is filled as bytes are driven and drained by a monitor on every mem_we cycle.
module tb_instr_loader;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       reload;
  logic       cpu_hold;
  logic       done;
  logic [5:0] word_count;

  int  checks = 0;
  int  errors = 0;
  wr_t expQ[$];

  instr_loader_if #(.ADDR_W(5)) bus ();

  instr_loader #(.ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .reload     (reload),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every write is compared against the oldest expectation; in_ready must be low while writing.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write_addr", {27'd0, bus.mem_a}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("write_addr", {27'd0, bus.mem_a}, {27'd0, e.a});
        checkOutput("write_data", bus.mem_d, e.d);
      end
      checkOutput("ready_low_in_write", {31'd0, bus.in_ready}, 32'd0);
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic applyStimulus(input logic [7:0] b, input logic last, input int maxGap);
    int gap;
    int waitCycles;
    gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
    repeat (gap) @(negedge clk);
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    waitCycles   = 0;
    while (bus.in_ready !== 1'b1 && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= 50) checkOutput("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_byte  = 8'h00;
  endtask

  task automatic sendWord(input logic [4:0] a, input logic [31:0] w, input logic last, input int maxGap);
    expQ.push_back('{a: a, d: w});
    applyStimulus(w[31:24], 1'b0, maxGap);
    applyStimulus(w[23:16], 1'b0, maxGap);
    applyStimulus(w[15:8],  1'b0, maxGap);
    applyStimulus(w[7:0],   last, maxGap);
  endtask

  task automatic checkDone(input string tag, input logic [5:0] expCount);
    @(negedge clk);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    checkOutput({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    checkOutput({tag, "_count"}, {26'd0, word_count}, {26'd0, expCount});
    checkOutput({tag, "_pending"}, expQ.size(), 32'd0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_a"}, {27'd0, bus.mem_a}, 32'd0);
    checkOutput({tag, "_d"}, bus.mem_d, 32'd0);
    checkOutput({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
    checkOutput({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_count"}, {26'd0, word_count}, 32'd0);
    checkOutput({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic doReload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("reload_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("reload_done", {31'd0, done}, 32'd0);
    checkOutput("reload_count", {26'd0, word_count}, 32'd0);
    checkOutput("reload_a", {27'd0, bus.mem_a}, 32'd0);
  endtask

  task automatic offerInDone(input string tag);
    bus.in_byte  = 8'h77;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    reload       = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkReset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] two-word program with in_last");
    sendWord(5'd0, 32'h3C01_1001, 1'b0, 0);
    sendWord(5'd1, 32'h8C22_0000, 1'b1, 0);
    checkOutput("write_cycle_done_low", {31'd0, done}, 32'd0);
    checkOutput("write_cycle_hold_high", {31'd0, cpu_hold}, 32'd1);
    checkDone("basic", 6'd2);
    offerInDone("basic_extra");

    $display("[TB] stalling host, reload ignored during LOAD");
    doReload();
    sendWord(5'd0, 32'h0102_0304, 1'b0, 3);
    expQ.push_back('{a: 5'd1, d: 32'hA0B1_C2D3});
    applyStimulus(8'hA0, 1'b0, 3);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checkOutput("reload_in_load_a", {27'd0, bus.mem_a}, 32'd1);
    checkOutput("reload_in_load_count", {26'd0, word_count}, 32'd1);
    applyStimulus(8'hB1, 1'b0, 3);
    applyStimulus(8'hC2, 1'b0, 3);
    applyStimulus(8'hD3, 1'b0, 3);
    sendWord(5'd2, 32'hFEED_F00D, 1'b1, 3);
    checkDone("stall", 6'd3);

    $display("[TB] short final word");
    doReload();
    sendWord(5'd0, 32'h1122_3344, 1'b0, 0);
    expQ.push_back('{a: 5'd1, d: 32'h5500_0000});
    applyStimulus(8'h55, 1'b1, 0);
    checkDone("short", 6'd2);

    $display("[TB] full memory without in_last");
    doReload();
    for (int i = 0; i < 32; i++) begin
      logic [7:0] k;
      k = 8'(i);
      sendWord(5'(i), {k, ~k, k ^ 8'h5A, 8'hC3}, 1'b0, 0);
    end
    checkDone("full", 6'd32);
    checkOutput("full_last_a", {27'd0, bus.mem_a}, 32'd31);
    offerInDone("full_extra");

    $display("[TB] reset in the middle of a word");
    doReload();
    sendWord(5'd0, 32'h1000_0001, 1'b0, 0);
    sendWord(5'd1, 32'h2000_0002, 1'b0, 0);
    sendWord(5'd2, 32'h3000_0003, 1'b0, 0);
    applyStimulus(8'hEE, 1'b0, 0);
    applyStimulus(8'hDD, 1'b0, 0);
    checkOutput("pre_reset_a", {27'd0, bus.mem_a}, 32'd3);
    #2 rst_n = 1'b0;
    #1 checkReset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sendWord(5'd0, 32'hCAFE_BABE, 1'b1, 0);
    checkDone("after_reset", 6'd1);

    $display("[TB] reload and load one word");
    doReload();
    sendWord(5'd0, 32'hDEAD_BEEF, 1'b1, 0);
    checkDone("reload", 6'd1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
